// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: launches one byte per tx_start pulse and tracks tx_busy, with a timeout if busy never rises.
// Define TXF_OVF_STICKY_EN for a sticky overflow flag cleared by ovf_clr; otherwise ovf is a one-cycle pulse.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      push,
  input  logic [7:0]                push_data,
  input  logic                      flush,
  input  logic                      ovf_clr,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic [CW-1:0]   cnt;
  logic            push_ok;
  logic            ovf_evt;
  logic            pop;

  assign level   = count;
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);

  // Full is judged at the start of the cycle, so a same-cycle launch never frees room for a push.
  assign push_ok = push && !full && !flush;
  assign ovf_evt = push && full && !flush;
  assign pop     = (state == IDLE) && !empty && !flush;

`ifndef TXF_OVF_STICKY_EN
  logic ovf_clr_unused;
  assign ovf_clr_unused = ovf_clr;
`endif

  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (pop)     rd_ptr <= rd_ptr + PW'(1);
        if (push_ok && !pop)      count <= count + LW'(1);
        else if (!push_ok && pop) count <= count - LW'(1);
      end

`ifdef TXF_OVF_STICKY_EN
      if (ovf_evt)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
`else
      ovf <= ovf_evt;
`endif

      case (state)
        IDLE: begin
          if (pop) begin
            state    <= LAUNCH;
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
          end
        end
        LAUNCH: begin
          state    <= WAIT_BUSY;
          tx_start <= 1'b0;
          cnt      <= '0;
        end
        WAIT_BUSY: begin
          // A transmitter that never acknowledges costs the byte, not the queue.
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(BUSY_TIMEOUT - 1)) state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a uart_tx busy responder and a launch-order scoreboard.
module tb_uart_tx_fifo;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       push;
  logic [7:0] push_data;
  logic       flush;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       ovf;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];

  // responder controls
  bit busy_hold = 0;
  bit busy_tie0 = 0;
  int busy_len  = 4;
  int bcnt      = 0;
  logic prev_start = 1'b0;

  uart_tx_fifo #(.DEPTH(16), .BUSY_TIMEOUT(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .push(push), .push_data(push_data),
    .flush(flush), .ovf_clr(ovf_clr), .full(full), .empty(empty),
    .level(level), .ovf(ovf), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart_tx stand-in plus launch scoreboard, both on the falling edge
  always @(negedge PCLK) begin
    if (tx_start === 1'b1) begin
      pulses++;
      chk("single_cycle_pulse", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_tx_start", 32'd1, 32'd0);
      end else begin
        chk("launch_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      if (!busy_tie0) begin
        tx_busy = 1'b1;
        bcnt    = busy_len;
      end
    end else if (tx_busy && !busy_hold) begin
      if (bcnt == 0) tx_busy = 1'b0;
      else bcnt--;
    end
    prev_start = tx_start;
  end

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_push(input logic [7:0] b, input bit expect_ok);
    push      = 1'b1;
    push_data = b;
    if (expect_ok) exp_q.push_back(b);
    tick;
    push = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int n;
    n = 0;
    while ((!empty || exp_q.size() != 0 || tx_busy) && n < maxc) begin
      tick;
      n++;
    end
    chk(tag, {31'd0, n < maxc}, 32'd1);
    repeat (3) tick;
  endtask

  initial begin
    int p0;
    int n;
    PRESET = 1'b1; push = 1'b0; push_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0;

    // 1: reset values, single byte
    repeat (2) tick;
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    PRESET = 1'b0;
    tick;
    do_push(8'hA5, 1);
    chk("t1_level_after_push", {27'd0, level}, 32'd1);
    chk("t1_no_start_yet", {31'd0, tx_start}, 32'd0);
    tick;
    chk("t1_tx_start", {31'd0, tx_start}, 32'd1);
    chk("t1_tx_data", {24'd0, tx_data}, 32'hA5);
    chk("t1_level_after_launch", {27'd0, level}, 32'd0);
    wait_drain("t1_drain", 60);
    chk("t1_pulses", pulses, 32'd1);
    chk("t1_tx_data_stable", {24'd0, tx_data}, 32'hA5);

    // 2/3: burst with busy held, fill to full, overflow
    p0 = pulses;
    busy_hold = 1;
    for (int i = 0; i < 16; i++) do_push(8'(i), 1);
    chk("t2_level15", {27'd0, level}, 32'd15);
    chk("t2_not_full", {31'd0, full}, 32'd0);
    do_push(8'h10, 1);
    chk("t2_level16", {27'd0, level}, 32'd16);
    chk("t2_full", {31'd0, full}, 32'd1);
    do_push(8'hFF, 0);
    chk("t3_level_after_drop", {27'd0, level}, 32'd16);
    chk("t3_ovf_set", {31'd0, ovf}, 32'd1);
    tick;
`ifdef TXF_OVF_STICKY_EN
    chk("t3_ovf_held", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    do_push(8'hFF, 0);
    ovf_clr = 1'b0;
    chk("t3_set_beats_clr", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("t3_ovf_cleared", {31'd0, ovf}, 32'd0);
`else
    chk("t3_ovf_pulse_end", {31'd0, ovf}, 32'd0);
    ovf_clr = 1'b1;
    do_push(8'hFF, 0);
    ovf_clr = 1'b0;
    chk("t3_ovf_pulse_again", {31'd0, ovf}, 32'd1);
    tick;
    chk("t3_ovf_pulse_end2", {31'd0, ovf}, 32'd0);
`endif
    busy_hold = 0;
    wait_drain("t2_drain", 400);
    chk("t2_pulse_count", pulses - p0, 32'd17);

    // 4: flush while byte in flight
    busy_hold = 1;
    p0 = pulses;
    for (int i = 0; i < 5; i++) do_push(8'h41 + 8'(i), 1);
    chk("t4_level4", {27'd0, level}, 32'd4);
    chk("t4_one_launch", pulses - p0, 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    exp_q.delete();
    chk("t4_flush_level", {27'd0, level}, 32'd0);
    chk("t4_flush_empty", {31'd0, empty}, 32'd1);
    flush = 1'b1;
    do_push(8'h77, 0);
    flush = 1'b0;
    chk("t4_flush_push_level", {27'd0, level}, 32'd0);
    chk("t4_flush_push_ovf", {31'd0, ovf}, 32'd0);
    busy_hold = 0;
    repeat (30) tick;
    chk("t4_no_more_launch", pulses - p0, 32'd1);

    // 5: busy never rises -> timeout, then next byte launches
    busy_tie0 = 1;
    do_push(8'h3C, 1);
    do_push(8'h3D, 1);
    chk("t5_first_start", {31'd0, tx_start}, 32'd1);
    chk("t5_first_data", {24'd0, tx_data}, 32'h3C);
    n = 0;
    do begin
      tick;
      n++;
    end while (tx_start !== 1'b1 && n < 40);
    chk("t5_timeout_gap", n, 32'd10);
    chk("t5_second_data", {24'd0, tx_data}, 32'h3D);
    repeat (20) tick;
    busy_tie0 = 0;

    // 6: reset during WAIT_DONE with 3 queued
    busy_hold = 1;
    for (int i = 0; i < 4; i++) do_push(8'h51 + 8'(i), 1);
    repeat (2) tick;
    chk("t6_level3", {27'd0, level}, 32'd3);
    PRESET = 1'b1;
    tick;
    exp_q.delete();
    chk("t6_rst_level", {27'd0, level}, 32'd0);
    chk("t6_rst_empty", {31'd0, empty}, 32'd1);
    chk("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("t6_rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("t6_rst_ovf", {31'd0, ovf}, 32'd0);
    busy_hold = 0;
    PRESET = 1'b0;
    p0 = pulses;
    repeat (20) tick;
    chk("t6_no_start_after_rst", pulses - p0, 32'd0);
    do_push(8'h99, 1);
    wait_drain("t6_drain", 60);
    chk("t6_relaunch", pulses - p0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
